// File: rtl/jtag_scan_master.sv
// Host-side JTAG initiator: runs one IR or DR scan per request, walking the TAP Idle -> Shift -> Idle.
// Optional JTAG_SCAN_MASTER_TAP_RESET_EN: after reset, drive TMS=1 x5 then TMS=0 to force the target into Run-Test/Idle.
`timescale 1ns/1ps
module jtag_scan_master #(
  parameter int MAX_BITS  = 64,
  parameter int CLK_DIV   = 4,
  parameter int LEN_WIDTH = $clog2(MAX_BITS + 1)
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iSTART,
  input  logic                 iIR_SCAN,
  input  logic [LEN_WIDTH-1:0] iLEN,
  input  logic [MAX_BITS-1:0]  iDATA,
  output logic [MAX_BITS-1:0]  oDATA,
  output logic                 oBUSY,
  output logic                 oDONE,
  output logic                 oTCK,
  output logic                 oTMS,
  output logic                 oTDI,
  input  logic                 iTDO
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_SHIFT, S_TAIL, S_FINISH, S_RST_ENTRY, S_TAP_RST
  } state_e;

  localparam int                   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(MAX_BITS);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
`ifdef JTAG_SCAN_MASTER_TAP_RESET_EN
  localparam state_e RESET_STATE = S_RST_ENTRY;
`else
  localparam state_e RESET_STATE = S_IDLE;
`endif

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                 busy_q, busy_d, done_q, done_d, ir_q, ir_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [MAX_BITS-1:0]  tx_q, tx_d, rx_q, rx_d, mask_q, mask_d;

  logic [LEN_WIDTH-1:0] len_in, cnt_inc, head_last;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ir_d    = ir_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    mask_d  = mask_q;

    len_in    = (iLEN > LEN_MAX) ? LEN_MAX : iLEN;
    cnt_inc   = cnt_q + LEN_ONE;
    head_last = ir_q ? LEN_WIDTH'(3) : LEN_WIDTH'(2);

    case (state_q)
      S_IDLE: begin
        if (iSTART && (len_in != '0)) begin
          state_d = S_HEAD;
          busy_d  = 1'b1;
          ir_d    = iIR_SCAN;
          len_d   = len_in;
          cnt_d   = '0;
          div_d   = '0;
          tck_d   = 1'b0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          tx_d    = iDATA;
          mask_d  = MAX_BITS'(1);
          rx_d    = rx_q & ~({MAX_BITS{1'b1}} << len_in);
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_RST_ENTRY: begin
        state_d = S_TAP_RST;
        busy_d  = 1'b1;
        tms_d   = 1'b1;
        cnt_d   = '0;
        div_d   = '0;
      end
      default: begin
        // TCK-generating states; each TCK period is one entry of the TMS walk.
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            if (state_q == S_SHIFT)
              rx_d = iTDO ? (rx_q | mask_q) : (rx_q & ~mask_q);
          end else begin
            cnt_d = cnt_inc;
            case (state_q)
              S_HEAD: begin
                tms_d = ir_q && (cnt_inc == LEN_ONE);
                if (cnt_q == head_last) begin
                  state_d = S_SHIFT;
                  cnt_d   = '0;
                  tms_d   = (len_q == LEN_ONE);
                  tdi_d   = tx_q[0];
                  tx_d    = tx_q >> 1;
                end
              end
              S_SHIFT: begin
                if (cnt_q == len_q - LEN_ONE) begin
                  state_d = S_TAIL;
                  cnt_d   = '0;
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
                end else begin
                  mask_d = mask_q << 1;
                  tms_d  = (cnt_inc == len_q - LEN_ONE);
                  tdi_d  = tx_q[0];
                  tx_d   = tx_q >> 1;
                end
              end
              S_TAIL: begin
                if (cnt_q == '0) begin
                  tms_d = 1'b0;
                end else begin
                  // TMS parks high so the next scan's first period needs no mid-low change.
                  state_d = S_FINISH;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  tms_d   = 1'b1;
                end
              end
              S_TAP_RST: begin
                if (cnt_q == LEN_WIDTH'(5)) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  tms_d   = 1'b1;
                end else begin
                  tms_d = (cnt_inc != LEN_WIDTH'(5));
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= RESET_STATE;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ir_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      mask_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ir_q    <= ir_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      mask_q  <= mask_d;
    end
  end

  assign oTCK  = tck_q;
  assign oTMS  = tms_q;
  assign oTDI  = tdi_q;
  assign oBUSY = busy_q;
  assign oDONE = done_q;
  assign oDATA = rx_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Self-checking bench for jtag_scan_master: TAP target model, scoreboard of expected scan results.
`timescale 1ns/1ps
module tb_jtag_scan_master;
  localparam int MAX_BITS = 32;
  localparam int LW       = $clog2(MAX_BITS + 1);
  localparam logic [31:0] DR_CAPTURE = 32'hCAFEF00D;
  localparam logic [9:0]  IR_CAPTURE = 10'h001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, ir_scan = 1'b0, tdo = 1'b0;
  logic [LW-1:0] ilen = '0;
  logic [31:0] din = '0, dout;
  logic busy, done, tck, tms, tdi;

  logic start2 = 1'b0;
  logic [LW-1:0] ilen2 = '0;
  logic [31:0] din2 = '0, dout2;
  logic busy2, done2, tck2, tms2, tdi2;

  jtag_scan_master #(.MAX_BITS(MAX_BITS), .CLK_DIV(2)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iIR_SCAN(ir_scan), .iLEN(ilen),
    .iDATA(din), .oDATA(dout), .oBUSY(busy), .oDONE(done), .oTCK(tck), .oTMS(tms),
    .oTDI(tdi), .iTDO(tdo));

  jtag_scan_master #(.MAX_BITS(MAX_BITS), .CLK_DIV(1)) dut2 (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start2), .iIR_SCAN(1'b0), .iLEN(ilen2),
    .iDATA(din2), .oDATA(dout2), .oBUSY(busy2), .oDONE(done2), .oTCK(tck2), .oTMS(tms2),
    .oTDI(tdi2), .iTDO(1'b1));

  // ---------------- TAP target model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  tap_e tap_q = RTI;
  logic [31:0] dr_sr = '0, dr_upd = '0;
  logic [9:0]  ir_sr = '0, ir_upd = '0;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PA_DR;
      PA_DR:  return m ? EX2_DR : PA_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PA_IR;
      PA_IR:  return m ? EX2_IR : PA_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_q)
      CAP_DR: dr_sr <= DR_CAPTURE;
      SH_DR:  dr_sr <= {tdi, dr_sr[31:1]};
      CAP_IR: ir_sr <= IR_CAPTURE;
      SH_IR:  ir_sr <= {tdi, ir_sr[9:1]};
      EX1_DR, EX2_DR: if (tms) dr_upd <= dr_sr;
      EX1_IR, EX2_IR: if (tms) ir_upd <= ir_sr;
      default: ;
    endcase
    tap_q <= tap_next(tap_q, tms);
  end

  always @(negedge tck)
    tdo <= (tap_q == SH_DR) ? dr_sr[0] : (tap_q == SH_IR) ? ir_sr[0] : 1'b0;

  // ---------------- monitors ----------------
  bit tms_hist[$];
  int tck_edges = 0;
  always @(posedge tck) begin
    tms_hist.push_back(tms);
    tck_edges = tck_edges + 1;
  end

  int tck2_edges = 0;
  always @(posedge tck2) tck2_edges = tck2_edges + 1;

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  // TMS/TDI may only move on the iCLK edge that takes TCK from high to low.
  int bad_edges = 0, pin_changes = 0;
  always @(posedge clk) begin
    logic p_tck, p_tms, p_tdi, p_rst;
    p_tck = tck; p_tms = tms; p_tdi = tdi; p_rst = rst_n;
    #1;
    if (p_rst && rst_n && (tms !== p_tms || tdi !== p_tdi)) begin
      pin_changes = pin_changes + 1;
      if (!(p_tck === 1'b1 && tck === 1'b0)) bad_edges = bad_edges + 1;
    end
  end

  // TCK2 rising-edge spacing in iCLK cycles, measured only within busy windows.
  int gap_min = 1000, gap_max = 0;
  always @(posedge clk) begin
    static int cyc = 0;
    static bit valid = 0;
    static logic p_tck2 = 1'b0;
    #1;
    if (!busy2) begin
      valid = 0;
    end else begin
      cyc = cyc + 1;
      if (tck2 && !p_tck2) begin
        if (valid) begin
          if (cyc < gap_min) gap_min = cyc;
          if (cyc > gap_max) gap_max = cyc;
        end
        valid = 1;
        cyc = 0;
      end
    end
    p_tck2 = tck2;
  end

  // ---------------- checking ----------------
  int checks = 0, passes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] data;
    logic [31:0] upd;
    int          edges;
    logic [63:0] tms;
  } exp_t;

  exp_t sb[$];
  int   scan_base = 0;

  function automatic exp_t mk(logic ir, logic [31:0] data, logic [31:0] upd, int edges,
                              logic [63:0] tms_v);
    exp_t e;
    e.ir = ir; e.data = data; e.upd = upd; e.edges = edges; e.tms = tms_v;
    return e;
  endfunction

  function automatic logic [63:0] pack_tms(int base, int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < 64; i++)
      if (base + i < tms_hist.size()) v[i] = tms_hist[base + i];
    return v;
  endfunction

  // Called at a negedge; leaves at the following negedge with iSTART low.
  task automatic launch_raw(input logic ir, input logic [LW-1:0] l, input logic [31:0] d);
    start = 1'b1; ir_scan = ir; ilen = l; din = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic launch(input string tag, input logic ir, input logic [LW-1:0] l,
                        input logic [31:0] d, input exp_t e);
    sb.push_back(e);
    scan_base = tck_edges;
    launch_raw(ir, l, d);
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
  endtask

  task automatic finish_scan(input string tag);
    exp_t e;
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, 64'(dout), 64'(e.data));
      check({tag, "_tck_edges"}, 64'(tck_edges - scan_base), 64'(e.edges));
      check({tag, "_tms_seq"}, pack_tms(scan_base, e.edges), e.tms);
      check({tag, "_target_upd"}, e.ir ? 64'(ir_upd) : 64'(dr_upd), 64'(e.upd));
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

`ifdef JTAG_SCAN_MASTER_TAP_RESET_EN
  task automatic wait_tap_reset(input string tag);
    int n = 0;
    int base = tck_edges;
    int dbase = done_cnt;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check({tag, "_rst_seq_busy"}, 64'(busy), 64'd1);
    n = 0;
    while ((busy || busy2) && n < 500) begin @(negedge clk); n++; end
    check({tag, "_rst_seq_end"}, 64'(busy), 64'd0);
    check({tag, "_rst_seq_edges"}, 64'(tck_edges - base), 64'd6);
    check({tag, "_rst_seq_tms"}, pack_tms(base, 6), 64'h1F);
    check({tag, "_rst_seq_no_done"}, 64'(done_cnt - dbase), 64'd0);
    check({tag, "_target_rti"}, 64'(tap_q), 64'(RTI));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    #12;
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(dout), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef JTAG_SCAN_MASTER_TAP_RESET_EN
    wait_tap_reset("por");
`else
    @(negedge clk);
`endif

    // Full-length DR scan.
    launch("dr32", 1'b0, LW'(32), 32'hA5A51234,
           mk(1'b0, DR_CAPTURE, 32'hA5A51234, 37, 64'hC_0000_0001));
    finish_scan("dr32");

    // IR scan; upper oDATA bits cleared at start.
    launch("ir10", 1'b1, LW'(10), 32'h0000_02AB,
           mk(1'b1, 32'h0000_0001, 32'h0000_02AB, 16, 64'h6003));
    finish_scan("ir10");

    // Zero length is ignored.
    base = tck_edges;
    n = done_cnt;
    launch_raw(1'b0, LW'(0), 32'hFFFF_FFFF);
    check("len0_busy", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    check("len0_no_tck", 64'(tck_edges - base), 64'd0);
    check("len0_no_done", 64'(done_cnt - n), 64'd0);

    // Over-long request clamps to MAX_BITS.
    launch("len40", 1'b0, LW'(40), 32'h0F0F5A5A,
           mk(1'b0, DR_CAPTURE, 32'h0F0F5A5A, 37, 64'hC_0000_0001));
    finish_scan("len40");

    // Single-bit and partial DR scans.
    launch("len1", 1'b0, LW'(1), 32'h0000_0000,
           mk(1'b0, 32'h0000_0001, 32'h657F7806, 6, 64'h19));
    finish_scan("len1");
    launch("len8", 1'b0, LW'(8), 32'h0000_003C,
           mk(1'b0, 32'h0000_000D, 32'h3CCAFEF0, 13, 64'hC01));
    finish_scan("len8");

    // iSTART mid-scan is ignored; next request back-to-back after oDONE.
    launch("midstart", 1'b0, LW'(32), 32'h12345678,
           mk(1'b0, DR_CAPTURE, 32'h12345678, 37, 64'hC_0000_0001));
    repeat (30) @(negedge clk);
    launch_raw(1'b1, LW'(10), 32'hFFFF_FFFF);
    check("midstart_still_busy", 64'(busy), 64'd1);
    finish_scan("midstart");
    launch("b2b", 1'b1, LW'(10), 32'h0000_0155,
           mk(1'b1, 32'h0000_0001, 32'h0000_0155, 16, 64'h6003));
    finish_scan("b2b");

    // CLK_DIV=1 instance: TCK runs at iCLK/2.
    base = tck2_edges;
    start2 = 1'b1; ilen2 = LW'(4); din2 = 32'h0;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 200) begin @(negedge clk); n++; end
    check("div1_done", 64'(done2), 64'd1);
    check("div1_data", 64'(dout2), 64'hF);
    check("div1_tck_edges", 64'(tck2_edges - base), 64'd9);
    check("div1_gap_min", 64'(gap_min), 64'd2);
    check("div1_gap_max", 64'(gap_max), 64'd2);

    check("pins_seen_moving", 64'(pin_changes > 0), 64'd1);
    check("pins_only_on_tck_fall", 64'(bad_edges), 64'd0);

    // Reset during shift bit 5 of a DR scan.
    @(negedge clk);
    base = tck_edges;
    launch_raw(1'b0, LW'(32), 32'hDEADBEEF);
    n = 0;
    while (!((tck_edges - base) == 8 && tck == 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_bit5", 64'(tck_edges - base), 64'd8);
    check("midrst_busy_before", 64'(busy), 64'd1);
    check("midrst_data_before", 64'(dout), 64'h0000_000D);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tck", 64'(tck), 64'd0);
    check("midrst_tms", 64'(tms), 64'd1);
    check("midrst_tdi", 64'(tdi), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_data", 64'(dout), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifdef JTAG_SCAN_MASTER_TAP_RESET_EN
    wait_tap_reset("midrst");
`else
    base = tck_edges;
    repeat (10) @(negedge clk);
    check("midrst_idle_busy", 64'(busy), 64'd0);
    check("midrst_idle_no_tck", 64'(tck_edges - base), 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side JTAG initiator that drives TCK/TMS/TDI and samples TDO to run one complete IR or DR scan per request.
- Lets on-chip logic or a test harness exercise JTAG target registers (e.g. the team's jtag_memory data registers) without an external probe.
- Walks the TAP from Run-Test/Idle through Shift and back to Run-Test/Idle, returning the captured TDO bits.

Parameters:
- MAX_BITS, 64, maximum scan length in bits; width of the data buses.
- CLK_DIV, 4, number of iCLK cycles per TCK half-period; must be >= 1.
- LEN_WIDTH, $clog2(MAX_BITS+1), width of iLEN (derived, not to be overridden).

Ports:
- iCLK  input  1  system clock; all logic is synchronous to its rising edge.
- iRST_N  input  1  asynchronous active-low reset.
- iSTART  input  1  one-cycle scan request; sampled only while idle.
- iIR_SCAN  input  1  1 = IR scan, 0 = DR scan; latched with iSTART.
- iLEN  input  LEN_WIDTH  scan length in bits; latched with iSTART.
- iDATA  input  MAX_BITS  bits to shift out on TDI, LSB first; latched with iSTART.
- oDATA  output  MAX_BITS  captured TDO bits; first bit received lands in bit 0.
- oBUSY  output  1  high from the cycle after an accepted iSTART until oDONE.
- oDONE  output  1  one-cycle pulse when the scan has completed.
- oTCK  output  1  JTAG test clock.
- oTMS  output  1  JTAG mode select.
- oTDI  output  1  JTAG data to the target.
- iTDO  input  1  JTAG data from the target; treated as synchronous to iCLK.

Behaviour:
- Reset values: oTCK=0, oTMS=1, oTDI=0, oBUSY=0, oDONE=0, oDATA=0, FSM=IDLE.
- Reset is honoured mid-scan: all outputs return to their reset values immediately. The TAP state is then unknown; see Optional Feature.
- Accepting a request: iSTART with 1 <= iLEN is accepted only in IDLE. oBUSY rises the next cycle.
  - iLEN=0 is ignored: no busy, no done.
  - iLEN > MAX_BITS is clamped to MAX_BITS.
  - iSTART while busy is ignored.
- TCK timing:
  - Each TCK period is low for CLK_DIV iCLK cycles, then high for CLK_DIV iCLK cycles.
  - oTMS and oTDI change only on the iCLK edge that drives oTCK low.
  - iTDO is sampled on the iCLK edge that drives oTCK high.
  - oTCK idles low.
- TMS sequence, one entry per TCK period:
  - DR scan: 1, 0, 0, then N shift periods, then 1, 0.
  - IR scan: 1, 1, 0, 0, then N shift periods, then 1, 0.
  - Shift periods carry TMS=0 for the first N-1 bits and TMS=1 on bit N (Exit1).
  - Total TCK periods: DR = N+5, IR = N+6.
- TDI: during shift period k (0-based), oTDI=iDATA[k]. Outside shift periods oTDI=0.
- TDO capture: the bit sampled in shift period k is written to oDATA[k].
  - oDATA bits at or above N are cleared at scan start.
  - oDATA holds its value until the next accepted scan.
- FSM states: IDLE -> HEAD (TMS prefix) -> SHIFT -> TAIL (Exit1/Update/Idle) -> FINISH -> IDLE.
  - FINISH lasts one iCLK cycle: oDONE=1 and oBUSY=0 in the same cycle.
  - A new iSTART is accepted in the cycle after FINISH.
- oTCK ends low after the final TMS=0 period. The target is left in Run-Test/Idle.
- Counters: the bit counter is LEN_WIDTH wide and the divider counter is $clog2(CLK_DIV) bits; neither wraps within a scan.

Optional Feature:
- Macro: JTAG_SCAN_MASTER_TAP_RESET_EN.
- Defined: after reset deassertion, the block drives 5 TCK periods with TMS=1, then 1 period with TMS=0, to force the target to Run-Test/Idle.
  - oBUSY=1 during this sequence and oDONE does not pulse.
  - iSTART is ignored until the sequence finishes.
- Undefined: the block enters IDLE directly after reset and assumes the target is already in Run-Test/Idle.

Test Plan:
- CLK_DIV=2, MAX_BITS=32, bench TAP model with a 32-bit DR capturing 0xCAFEF00D. DR scan, iLEN=32, iDATA=0xA5A51234 -> oDATA=0xCAFEF00D, model update register=0xA5A51234, exactly 37 TCK rising edges, oDONE one cycle.
- IR scan, iLEN=10, iDATA=0x2AB, model IR capture=0x001 -> TMS sequence 1,1,0,0,0x9,1,1,0; oDATA=0x001; model IR=0x2AB; 16 TCK edges.
- iLEN=0 -> oBUSY stays 0, no TCK edges. iLEN=40 -> behaves as iLEN=32.
- iSTART pulsed mid-scan with different data -> ignored; first scan result unchanged; back-to-back iSTART in the cycle after oDONE is accepted.
- Assert iRST_N=0 during bit 5 of a DR scan -> same cycle: oTCK=0, oTMS=1, oBUSY=0, oDATA=0. With JTAG_SCAN_MASTER_TAP_RESET_EN, after release expect 5×TMS=1 then TMS=0, and the model reaches Run-Test/Idle.
- Check that oTMS/oTDI only change on the TCK-falling iCLK edge, and that CLK_DIV=1 yields TCK = iCLK/2.
